// File: rtl/rs_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rs_ctrl_pkg
// Shared constants and types for the RS(15,11) decoder control path.
//   RS_N / RS_K      : codeword length and data symbols per codeword
//   SYM_W            : width of a symbol/position index
//   RS_KES_TIMEOUT   : cycles the scheduler waits for the key-equation solver
//   PHASE_*          : externally visible phase codes
//   rs_state_e       : scheduler state, encoded with the PHASE codes
// ---------------------------------------------------------------------------
package rs_ctrl_pkg;

  localparam int RS_N           = 15;
  localparam int RS_K           = 11;
  localparam int SYM_W          = 4;
  localparam int RS_KES_TIMEOUT = 16;

  localparam logic [2:0] PHASE_IDLE   = 3'd0;
  localparam logic [2:0] PHASE_LOAD   = 3'd1;
  localparam logic [2:0] PHASE_SOLVE  = 3'd2;
  localparam logic [2:0] PHASE_SEARCH = 3'd3;
  localparam logic [2:0] PHASE_EMIT   = 3'd4;

  // The state encoding is the phase code itself, so PHASE is a plain copy
  // of the state register.
  typedef enum logic [2:0] {
    ST_IDLE   = PHASE_IDLE,
    ST_LOAD   = PHASE_LOAD,
    ST_SOLVE  = PHASE_SOLVE,
    ST_SEARCH = PHASE_SEARCH,
    ST_EMIT   = PHASE_EMIT
  } rs_state_e;

  // Converts an integer position into a symbol index of the shared width.
  function automatic logic [SYM_W-1:0] to_sym_idx(input int value);
    return SYM_W'(value);
  endfunction

endpackage

// File: rtl/rs_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// rs_frame_scheduler_if
// Bundles every handshake and control signal between the frame scheduler
// and the datapath units around it.
//   master : the scheduler (drives ready/enables/index/phase/status)
//   slave  : source, solver, search unit and sink (drive valid/done/flags)
// Signals:
//   in_valid/in_ready     symbol input handshake
//   kes_done, kes_start   key-equation solver start/done
//   uncorr                search unit uncorrectable flag
//   out_valid/out_ready   data symbol output handshake
//   syn_en, syn_first     syndrome accumulate / load controls
//   chien_en              search position enable
//   sym_idx, phase        current index and phase code
//   fail, frame_done      frame status
// ---------------------------------------------------------------------------
interface rs_frame_scheduler_if;
  import rs_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             kes_done;
  logic             uncorr;
  logic             out_ready;
  logic             syn_en;
  logic             syn_first;
  logic             kes_start;
  logic             chien_en;
  logic             out_valid;
  logic [SYM_W-1:0] sym_idx;
  logic [2:0]       phase;
  logic             fail;
  logic             frame_done;

  modport master (
    input  in_valid, kes_done, uncorr, out_ready,
    output in_ready, syn_en, syn_first, kes_start, chien_en, out_valid,
           sym_idx, phase, fail, frame_done
  );

  modport slave (
    output in_valid, kes_done, uncorr, out_ready,
    input  in_ready, syn_en, syn_first, kes_start, chien_en, out_valid,
           sym_idx, phase, fail, frame_done
  );

endinterface

// File: rtl/rs_sym_counter.sv
// ---------------------------------------------------------------------------
// rs_sym_counter
// Symbol/position index counter with synchronous clear and enable, plus a
// compare against a caller-supplied terminal value.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : load zero (wins over i_en)
//   i_en           : increment by one
//   i_tc_value     : terminal value to compare against
//   o_count        : current index
//   o_at_tc        : o_count equals i_tc_value
// ---------------------------------------------------------------------------
module rs_sym_counter
  import rs_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [SYM_W-1:0] i_tc_value,
  output logic [SYM_W-1:0] o_count,
  output logic             o_at_tc
);

  logic [SYM_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_at_tc = (r_count == i_tc_value);

endmodule

// File: rtl/rs_frame_scheduler.sv
// ---------------------------------------------------------------------------
// rs_frame_scheduler
// Handshake-driven frame sequencer for the RS(15,11) decoder. One codeword
// is taken in (LOAD), the key-equation solver is started and awaited with a
// timeout (SOLVE), the Chien/Forney search is stepped over every position
// (SEARCH) and the K data symbols are handed to the sink (EMIT).
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset; aborts any frame in flight
//   bus     : rs_frame_scheduler_if.master, all handshake/control signals
// Parameters: N (codeword symbols), K (data symbols), KES_TIMEOUT (solver
// wait limit in cycles).
// ---------------------------------------------------------------------------
module rs_frame_scheduler
  import rs_ctrl_pkg::*;
#(
  parameter int N           = RS_N,
  parameter int K           = RS_K,
  parameter int KES_TIMEOUT = RS_KES_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rs_frame_scheduler_if.master bus
);

  localparam int TIMER_W = $clog2(KES_TIMEOUT);

  localparam logic [SYM_W-1:0]   LAST_SYM   = SYM_W'(N - 1);
  localparam logic [SYM_W-1:0]   LAST_DATA  = SYM_W'(K - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(KES_TIMEOUT - 1);

  rs_state_e          r_state;
  rs_state_e          w_next_state;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_next_timer;
  logic               r_fail;
  logic               w_next_fail;
  logic               r_kes_start;
  logic               w_next_kes_start;
  logic               r_frame_done;
  logic               w_next_frame_done;

  logic               w_cnt_clear;
  logic               w_cnt_en;
  logic [SYM_W-1:0]   w_tc_value;
  logic [SYM_W-1:0]   w_sym_idx;
  logic               w_at_tc;

  logic               w_in_ready;
  logic               w_in_hs;
  logic               w_out_hs;

  // Ready is a pure state decode, forced low while reset is held so the
  // source never sees a handshake that the scheduler cannot record.
  assign w_in_ready = i_rst_n && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_in_hs    = bus.in_valid && w_in_ready;
  assign w_out_hs   = (r_state == ST_EMIT) && bus.out_ready;

  rs_sym_counter u_sym_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_cnt_clear),
    .i_en       (w_cnt_en),
    .i_tc_value (w_tc_value),
    .o_count    (w_sym_idx),
    .o_at_tc    (w_at_tc)
  );

  // Next-state and next-register logic. The index counter is retargeted per
  // phase: the last codeword position while loading and searching, the last
  // data position while emitting. Every phase exit clears the index so each
  // phase starts counting from position 0.
  always_comb begin
    w_next_state      = r_state;
    w_next_timer      = '0;
    w_next_fail       = r_fail;
    w_next_kes_start  = 1'b0;
    w_next_frame_done = 1'b0;
    w_cnt_clear       = 1'b0;
    w_cnt_en          = 1'b0;
    w_tc_value        = LAST_SYM;

    case (r_state)
      ST_IDLE: begin
        if (w_in_hs) begin
          w_next_state = ST_LOAD;
          w_next_fail  = 1'b0;
          w_cnt_en     = 1'b1;
        end
      end

      ST_LOAD: begin
        if (w_in_hs) begin
          if (w_at_tc) begin
            w_next_state     = ST_SOLVE;
            w_next_kes_start = 1'b1;
            w_cnt_clear      = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end

      ST_SOLVE: begin
        // A done pulse on the final timer cycle still counts as success, so
        // it is tested before the timeout.
        w_next_timer = r_timer + 1'b1;
        if (bus.kes_done) begin
          w_next_state = ST_SEARCH;
          w_next_timer = '0;
          w_cnt_clear  = 1'b1;
        end else if (r_timer == TIMER_LAST) begin
          w_next_state = ST_EMIT;
          w_next_fail  = 1'b1;
          w_next_timer = '0;
          w_cnt_clear  = 1'b1;
        end
      end

      ST_SEARCH: begin
        if (w_at_tc) begin
          w_next_state = ST_EMIT;
          w_next_fail  = r_fail | bus.uncorr;
          w_cnt_clear  = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      ST_EMIT: begin
        w_tc_value = LAST_DATA;
        if (w_out_hs) begin
          if (w_at_tc) begin
            w_next_state      = ST_IDLE;
            w_next_frame_done = 1'b1;
            w_cnt_clear       = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = ST_IDLE;
        w_cnt_clear  = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_fail       <= 1'b0;
      r_kes_start  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= w_next_timer;
      r_fail       <= w_next_fail;
      r_kes_start  <= w_next_kes_start;
      r_frame_done <= w_next_frame_done;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.syn_en     = w_in_hs;
  assign bus.syn_first  = w_in_hs && (r_state == ST_IDLE);
  assign bus.kes_start  = r_kes_start;
  assign bus.chien_en   = (r_state == ST_SEARCH);
  assign bus.out_valid  = (r_state == ST_EMIT);
  assign bus.sym_idx    = w_sym_idx;
  assign bus.phase      = r_state;
  assign bus.fail       = r_fail;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_rs_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rs_frame_scheduler
// Self-checking bench for rs_frame_scheduler. Frames are driven with
// directed and randomized source gaps, solver latencies, uncorrectable
// flags and sink back-pressure. A frame-level scoreboard counts the
// per-phase events and compares them with what the decoding rules demand.
// ---------------------------------------------------------------------------
module tb_rs_frame_scheduler;
  import rs_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  rs_frame_scheduler_if bus ();

  rs_frame_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Frame scoreboard, filled by the monitor on the falling edge.
  bit monOn = 0;
  int synEnCnt, synFirstCnt, kesStartCnt, chienCnt, outCnt, doneCnt;
  int firstHsCycle, firstOutCycle;
  bit outSeen, failChkPending, solvePending, holdPending;
  logic failInEmit;
  logic expFail;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearScore();
    synEnCnt       = 0;
    synFirstCnt    = 0;
    kesStartCnt    = 0;
    chienCnt       = 0;
    outCnt         = 0;
    doneCnt        = 0;
    firstHsCycle   = 0;
    firstOutCycle  = 0;
    outSeen        = 0;
    failChkPending = 0;
    solvePending   = 0;
    holdPending    = 0;
    failInEmit     = 1'b0;
  endtask

  // Falling-edge monitor: checks indices against the number of handshakes
  // seen so far and accumulates per-frame event counts.
  always @(negedge clk) begin
    if (monOn && rstN) begin
      if (failChkPending) begin
        checkOutput("fail_clear_first_sym", bus.fail, 0);
        failChkPending = 0;
      end
      if (solvePending) begin
        checkOutput("solve_entry_phase", bus.phase, 2);
        solvePending = 0;
      end
      if (holdPending) begin
        checkOutput("emit_hold_valid", bus.out_valid, 1);
        holdPending = 0;
      end
      if (bus.in_ready && synEnCnt < RS_N)
        checkOutput("load_idx", bus.sym_idx, synEnCnt);
      if (bus.syn_en) begin
        if (bus.syn_first) begin
          synFirstCnt++;
          firstHsCycle   = cycle;
          failChkPending = 1;
        end
        synEnCnt++;
        if (synEnCnt == RS_N) solvePending = 1;
      end
      if (bus.kes_start) kesStartCnt++;
      if (bus.chien_en) begin
        checkOutput("search_idx", bus.sym_idx, chienCnt);
        chienCnt++;
      end
      if (bus.out_valid) begin
        if (!outSeen) begin
          outSeen       = 1;
          firstOutCycle = cycle;
          failInEmit    = bus.fail;
        end
        checkOutput("emit_idx", bus.sym_idx, outCnt);
        checkOutput("emit_fail", bus.fail, expFail);
        if (bus.out_ready) outCnt++;
        else holdPending = 1;
      end
      if (bus.frame_done) doneCnt++;
    end
  end

  // Drives one frame. gapMode: 0 none, 1 every other cycle, 2 random.
  // kesDelay: solve cycle (0-based) carrying KES_DONE, negative for never.
  // uncorrMode: 0 none, 1 at position 14, 2 at position 7 only,
  // 3 random flags on positions other than 14 plus stray KES_DONE pulses.
  // abortAt: output index at which reset is asserted, negative for none.
  task automatic applyStimulus(input int gapMode, input int kesDelay,
                               input int uncorrMode, input int stallAt,
                               input int stallLen, input bit randReady,
                               input int abortAt);
    int  solveT    = -1;
    int  stallLeft = stallLen;
    int  budget    = 0;
    bit  done      = 0;
    bit  aborted   = 0;
    bit  timedOut;
    int  solveCycles;
    int  expLatency;

    timedOut = (kesDelay < 0) || (kesDelay >= RS_KES_TIMEOUT);
    expFail  = timedOut || (uncorrMode == 1);
    clearScore();
    monOn = 1;

    while (!done && budget < 600) begin
      @(posedge clk);
      #1;
      budget++;

      if (synEnCnt < RS_N) begin
        case (gapMode)
          1:       bus.in_valid = (budget % 2 == 0);
          2:       bus.in_valid = 1'($urandom_range(0, 1));
          default: bus.in_valid = 1'b1;
        endcase
      end else begin
        bus.in_valid = 1'b0;
      end

      if (bus.kes_start) solveT = 0;
      else if (solveT >= 0) solveT++;
      bus.kes_done = (solveT >= 0) && (solveT == kesDelay);
      if (uncorrMode == 3 && bus.in_ready && $urandom_range(0, 3) == 0)
        bus.kes_done = 1'b1;

      bus.uncorr = 1'b0;
      if (bus.chien_en) begin
        case (uncorrMode)
          1:       bus.uncorr = (bus.sym_idx == 4'd14);
          2:       bus.uncorr = (bus.sym_idx == 4'd7);
          3:       bus.uncorr = (bus.sym_idx != 4'd14) && ($urandom_range(0, 1) == 1);
          default: bus.uncorr = 1'b0;
        endcase
      end

      if (bus.out_valid && outCnt == stallAt && stallLeft > 0) begin
        bus.out_ready = 1'b0;
        stallLeft--;
      end else begin
        bus.out_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      end

      if (abortAt >= 0 && bus.out_valid && outCnt == abortAt) begin
        rstN = 1'b0;
        #1;
        checkOutput("abort_phase", bus.phase, 0);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_sym_idx", bus.sym_idx, 0);
        checkOutput("abort_in_ready", bus.in_ready, 0);
        aborted = 1;
        done    = 1;
      end

      if (doneCnt > 0) done = 1;
    end

    checkOutput("frame_completed", done, 1);
    if (!aborted) begin
      solveCycles = timedOut ? RS_KES_TIMEOUT : kesDelay + 1;
      expLatency  = RS_N + solveCycles + (timedOut ? 0 : RS_N);
      checkOutput("syn_en_count", synEnCnt, RS_N);
      checkOutput("syn_first_count", synFirstCnt, 1);
      checkOutput("kes_start_count", kesStartCnt, 1);
      checkOutput("chien_count", chienCnt, timedOut ? 0 : RS_N);
      checkOutput("out_count", outCnt, RS_K);
      checkOutput("frame_done_count", doneCnt, 1);
      checkOutput("fail_in_emit", failInEmit, expFail);
      checkOutput("fail_hold_after_frame", bus.fail, expFail);
      checkOutput("idle_after_frame", bus.phase, 0);
      if (gapMode == 0)
        checkOutput("first_out_latency", firstOutCycle - firstHsCycle, expLatency);
    end
    monOn = 0;
    bus.kes_done = 1'b0;
    bus.uncorr   = 1'b0;
  endtask

  initial begin
    int abortDone;

    bus.in_valid  = 1'b1;
    bus.kes_done  = 1'b0;
    bus.uncorr    = 1'b0;
    bus.out_ready = 1'b0;
    rstN          = 1'b0;
    clearScore();
    expFail = 1'b0;

    // Reset held with a pending source symbol: nothing may be accepted.
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_syn_en", bus.syn_en, 0);
    checkOutput("rst_syn_first", bus.syn_first, 0);
    checkOutput("rst_kes_start", bus.kes_start, 0);
    checkOutput("rst_chien_en", bus.chien_en, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_sym_idx", bus.sym_idx, 0);
    checkOutput("rst_phase", bus.phase, 0);
    checkOutput("rst_fail", bus.fail, 0);
    checkOutput("rst_frame_done", bus.frame_done, 0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rstN          = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_phase", bus.phase, 0);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    $display("[TB] back-to-back frames, solver done on 3rd cycle");
    applyStimulus(0, 2, 0, -1, 0, 0, -1);
    applyStimulus(0, 2, 0, -1, 0, 0, -1);

    $display("[TB] input gaps every other cycle");
    applyStimulus(1, 0, 0, -1, 0, 0, -1);

    $display("[TB] solver never answers");
    applyStimulus(0, -1, 0, -1, 0, 0, -1);

    $display("[TB] fail cleared by next frame, uncorrectable at position 14");
    applyStimulus(0, 2, 1, -1, 0, 0, -1);

    $display("[TB] uncorrectable flag only at position 7");
    applyStimulus(0, 2, 2, -1, 0, 0, -1);

    $display("[TB] solver done on the timeout cycle");
    applyStimulus(0, RS_KES_TIMEOUT - 1, 0, -1, 0, 0, -1);

    $display("[TB] sink stalls 5 cycles at index 4");
    applyStimulus(0, 1, 0, 4, 5, 0, -1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] reset during emit");
    applyStimulus(0, 2, 0, -1, 0, 0, 3);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    abortDone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.frame_done) abortDone++;
    end
    checkOutput("abort_no_frame_done", abortDone, 0);
    checkOutput("abort_idle_phase", bus.phase, 0);

    $display("[TB] frame after abort");
    applyStimulus(0, 4, 0, -1, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
